// File: rtl/uart_mmio_bridge_pkg.sv
// Shared definitions for the UART MMIO bridge: register offsets,
// CON bit positions and the TX/RX state encodings.
package uart_mmio_bridge_pkg;

   // Register offsets relative to BASE_ADDR
   localparam logic [31:0] TXD_OFF = 32'h0000_0000;
   localparam logic [31:0] RXD_OFF = 32'h0000_0004;
   localparam logic [31:0] CON_OFF = 32'h0000_0008;

   // CON register bit positions
   localparam int CON_SEND_EN     = 0;
   localparam int CON_RECV_EN     = 1;
   localparam int CON_TX_FULL     = 2;
   localparam int CON_RX_NONEMPTY = 3;
   localparam int CON_TX_BUSY     = 4;
   localparam int CON_RX_OVF      = 5;
   localparam int CON_IRQ_EN      = 6;
   localparam int CON_TX_OVF      = 7;

   typedef enum logic [2:0] {
      TX_IDLE      = 3'd0,
      TX_LOAD      = 3'd1,
      TX_TRIG      = 3'd2,
      TX_WAIT_BUSY = 3'd3,
      TX_WAIT_DONE = 3'd4
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE     = 2'd0,
      RX_CAPTURE  = 2'd1,
      RX_ACK      = 2'd2,
      RX_WAIT_CLR = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with extra-MSB pointers (equal = empty, MSB differs = full).
//
// Handshake: a push is accepted only on a cycle where push=1 and full=0;
// a pop is accepted only on a cycle where pop=1 and empty=0. Requests made
// against full/empty are ignored by the FIFO. dout always shows the head
// entry and is only meaningful while empty=0. Push and pop accepted in the
// same cycle both take effect and leave the occupancy unchanged.
module uart_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic [7:0]  mem_q [DEPTH];
   logic        push_ok;
   logic        pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer update; reset discards contents by equalising the pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_mmio_bridge.sv
// CPU-bus to UART transceiver bridge: TX/RX byte FIFOs, send/receive
// handshake sequencers, CON status/control register and a level interrupt.
module uart_mmio_bridge
   import uart_mmio_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h4000_0018,
   parameter int          FIFO_DEPTH   = 4,
   parameter int          PULSE_CYCLES = 2
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        mem_wr,
   input  logic        mem_rd,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   output logic [7:0]  writedata,
   output logic        send_trigger,
   output logic        send_enable,
   input  logic        send_state,
   output logic        recv_enable,
   input  logic        recv_state,
   output logic        Uart_state_trigger,
   input  logic [7:0]  readdata
);

   localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
   localparam logic [PW-1:0] CNT_ONE    = PW'(1);

   // Address decode
   logic txd_hit, rxd_hit, con_hit;
   assign txd_hit = (addr == BASE_ADDR + TXD_OFF);
   assign rxd_hit = (addr == BASE_ADDR + RXD_OFF);
   assign con_hit = (addr == BASE_ADDR + CON_OFF);

   // Control / status registers
   logic send_enable_q, recv_enable_q, irq_en_q;
   logic tx_ovf_q, rx_ovf_q, irq_q;

   // Synchronizers for the transceiver's asynchronous status lines
   logic send_sync1_q, send_sync_q;
   logic recv_sync1_q, recv_sync_q, recv_prev_q;
   logic recv_rise;

   // FSM state, exposed as named typed registers for observation
   tx_state_e      tx_state_q;
   rx_state_e      rx_state_q;
   logic [PW-1:0]  tx_cnt_q, rx_cnt_q;
   logic [7:0]     writedata_q;
   logic           send_trigger_q, recv_ack_q;

   // FIFO interfaces
   logic       tx_push, tx_pop, tx_full, tx_empty;
   logic       rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0] tx_dout, rx_dout;
   logic       tx_busy;
   logic       con_wr;
   logic [7:0] con_rd;
   logic       unused_wdata;

   assign con_wr       = mem_wr && con_hit;
   assign tx_push      = mem_wr && txd_hit;
   assign tx_pop       = (tx_state_q == TX_LOAD);
   assign rx_push      = (rx_state_q == RX_CAPTURE);
   assign rx_pop       = mem_rd && rxd_hit;
   assign tx_busy      = (tx_state_q != TX_IDLE);
   assign recv_rise    = recv_sync_q && !recv_prev_q;
   assign unused_wdata = ^{wdata[31:8], wdata[4:2]};

   uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (sysclk),
      .rst   (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (wdata[7:0]),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty)
   );

   uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (sysclk),
      .rst   (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (readdata),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // Two-flop synchronizers plus the previous recv sample for edge detect
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         send_sync1_q <= 1'b1;
         send_sync_q  <= 1'b1;
         recv_sync1_q <= 1'b0;
         recv_sync_q  <= 1'b0;
         recv_prev_q  <= 1'b0;
      end else begin
         send_sync1_q <= send_state;
         send_sync_q  <= send_sync1_q;
         recv_sync1_q <= recv_state;
         recv_sync_q  <= recv_sync1_q;
         recv_prev_q  <= recv_sync_q;
      end
   end

   // CON fields, sticky overflow flags and the registered interrupt
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         send_enable_q <= 1'b0;
         recv_enable_q <= 1'b0;
         irq_en_q      <= 1'b0;
         tx_ovf_q      <= 1'b0;
         rx_ovf_q      <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         if (con_wr) begin
            send_enable_q <= wdata[CON_SEND_EN];
            recv_enable_q <= wdata[CON_RECV_EN];
            irq_en_q      <= wdata[CON_IRQ_EN];
         end
         if (tx_push && tx_full)              tx_ovf_q <= 1'b1;
         else if (con_wr && wdata[CON_TX_OVF]) tx_ovf_q <= 1'b0;
         // A new overflow wins over a simultaneous clear so it is never lost
         if (rx_push && rx_full)              rx_ovf_q <= 1'b1;
         else if (con_wr && wdata[CON_RX_OVF]) rx_ovf_q <= 1'b0;
         irq_q <= irq_en_q && (!rx_empty || (!tx_busy && tx_empty));
      end
   end

   // TX sequencer: load a byte, pulse send_trigger, follow send_state low then high
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         tx_state_q     <= TX_IDLE;
         tx_cnt_q       <= '0;
         writedata_q    <= 8'h00;
         send_trigger_q <= 1'b1;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (!tx_empty && send_enable_q) tx_state_q <= TX_LOAD;
            end
            TX_LOAD: begin
               writedata_q    <= tx_dout;
               send_trigger_q <= 1'b0;
               tx_cnt_q       <= PULSE_LAST;
               tx_state_q     <= TX_TRIG;
            end
            TX_TRIG: begin
               if (tx_cnt_q == '0) begin
                  send_trigger_q <= 1'b1;
                  tx_state_q     <= TX_WAIT_BUSY;
               end else begin
                  tx_cnt_q <= tx_cnt_q - CNT_ONE;
               end
            end
            TX_WAIT_BUSY: begin
               if (!send_sync_q) tx_state_q <= TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
               if (send_sync_q) tx_state_q <= TX_IDLE;
            end
            default: begin
               tx_state_q     <= TX_IDLE;
               send_trigger_q <= 1'b1;
            end
         endcase
      end
   end

   // RX sequencer: capture on recv_state rise, pulse the ack, wait for release
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         recv_ack_q <= 1'b1;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               if (recv_rise && recv_enable_q) rx_state_q <= RX_CAPTURE;
            end
            RX_CAPTURE: begin
               recv_ack_q <= 1'b0;
               rx_cnt_q   <= PULSE_LAST;
               rx_state_q <= RX_ACK;
            end
            RX_ACK: begin
               if (rx_cnt_q == '0) begin
                  recv_ack_q <= 1'b1;
                  rx_state_q <= RX_WAIT_CLR;
               end else begin
                  rx_cnt_q <= rx_cnt_q - CNT_ONE;
               end
            end
            RX_WAIT_CLR: begin
               if (!recv_sync_q) rx_state_q <= RX_IDLE;
            end
            default: begin
               rx_state_q <= RX_IDLE;
               recv_ack_q <= 1'b1;
            end
         endcase
      end
   end

   // CON read image
   always_comb begin
      con_rd                  = 8'h00;
      con_rd[CON_SEND_EN]     = send_enable_q;
      con_rd[CON_RECV_EN]     = recv_enable_q;
      con_rd[CON_TX_FULL]     = tx_full;
      con_rd[CON_RX_NONEMPTY] = !rx_empty;
      con_rd[CON_TX_BUSY]     = tx_busy;
      con_rd[CON_RX_OVF]      = rx_ovf_q;
      con_rd[CON_IRQ_EN]      = irq_en_q;
      con_rd[CON_TX_OVF]      = tx_ovf_q;
   end

   // Read mux, combinational from addr; unmapped and TXD read as zero
   always_comb begin
      rdata = 32'h0000_0000;
      if (rxd_hit && !rx_empty) rdata = {24'h000000, rx_dout};
      else if (con_hit)         rdata = {24'h000000, con_rd};
   end

   assign irq                = irq_q;
   assign writedata          = writedata_q;
   assign send_trigger       = send_trigger_q;
   assign Uart_state_trigger = recv_ack_q;
   assign send_enable        = send_enable_q;
   assign recv_enable        = recv_enable_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge with simple transmitter/receiver models.
module tb_uart_mmio_bridge;

   localparam logic [31:0] TXD = 32'h4000_0018;
   localparam logic [31:0] RXD = 32'h4000_001C;
   localparam logic [31:0] CON = 32'h4000_0020;

   logic        sysclk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        mem_wr;
   logic        mem_rd;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic [7:0]  writedata;
   logic        send_trigger;
   logic        send_enable;
   logic        send_state;
   logic        recv_enable;
   logic        recv_state;
   logic        Uart_state_trigger;
   logic [7:0]  readdata;

   int tests_run    = 0;
   int tests_failed = 0;

   uart_mmio_bridge dut (
      .sysclk             (sysclk),
      .reset              (reset),
      .addr               (addr),
      .mem_wr             (mem_wr),
      .mem_rd             (mem_rd),
      .wdata              (wdata),
      .rdata              (rdata),
      .irq                (irq),
      .writedata          (writedata),
      .send_trigger       (send_trigger),
      .send_enable        (send_enable),
      .send_state         (send_state),
      .recv_enable        (recv_enable),
      .recv_state         (recv_state),
      .Uart_state_trigger (Uart_state_trigger),
      .readdata           (readdata)
   );

   // Clock
   always #5 sysclk = ~sysclk;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge sysclk);
      addr = a; wdata = d; mem_wr = 1'b1;
      @(negedge sysclk);
      mem_wr = 1'b0; addr = 32'h0; wdata = 32'h0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge sysclk);
      addr = a; mem_rd = 1'b1;
      #1 d = rdata;
      @(negedge sysclk);
      mem_rd = 1'b0; addr = 32'h0;
   endtask

   // Transmitter model: wait for the trigger, measure it, then go busy for a while
   task automatic tx_model_byte(input int busy_cycles, output logic [7:0] b, output int width);
      b = 8'h00;
      width = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge sysclk);
         if (send_trigger === 1'b0) break;
      end
      if (send_trigger !== 1'b0) return;
      b = writedata;
      width = 1;
      for (int n = 0; n < 20; n++) begin
         @(negedge sysclk);
         if (send_trigger !== 1'b0) break;
         width++;
      end
      send_state = 1'b0;
      repeat (busy_cycles) @(negedge sysclk);
      send_state = 1'b1;
   endtask

   // Receiver model: present a byte, measure the ack pulse, then release
   task automatic rx_model_byte(input logic [7:0] b, output int width);
      width = 0;
      @(negedge sysclk);
      readdata = b; recv_state = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge sysclk);
         if (Uart_state_trigger === 1'b0) break;
      end
      if (Uart_state_trigger === 1'b0) begin
         width = 1;
         for (int n = 0; n < 20; n++) begin
            @(negedge sysclk);
            if (Uart_state_trigger !== 1'b0) break;
            width++;
         end
      end
      recv_state = 1'b0;
      readdata = 8'h00;
      repeat (6) @(negedge sysclk);
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      logic [31:0] v;
      @(negedge sysclk);
      tests_run++; if (rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h required 0", rdata); end
      tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b required 0", irq); end
      tests_run++; if (writedata !== 8'h00) begin tests_failed++; $display("FAIL reset_writedata: got %h required 00", writedata); end
      tests_run++; if (send_trigger !== 1'b1) begin tests_failed++; $display("FAIL reset_send_trigger: got %b required 1", send_trigger); end
      tests_run++; if (Uart_state_trigger !== 1'b1) begin tests_failed++; $display("FAIL reset_recv_ack: got %b required 1", Uart_state_trigger); end
      tests_run++; if (send_enable !== 1'b0 || recv_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_enables: got %b%b required 00", send_enable, recv_enable); end
      reset = 1'b0;
      bus_read(CON, v);
      tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_con: got %h required 00000000", v); end
      tests_run++; if (irq !== 1'b0 || send_trigger !== 1'b1) begin tests_failed++; $display("FAIL reset_idle_outputs: got irq=%b trig=%b required irq=0 trig=1", irq, send_trigger); end
   endtask

   task automatic test_tx_single();
      logic [31:0] v;
      logic [7:0]  b;
      int          w;
      bus_write(CON, 32'h01);
      tests_run++; if (send_enable !== 1'b1) begin tests_failed++; $display("FAIL tx1_send_enable: got %b required 1", send_enable); end
      bus_write(TXD, 32'h55);
      tx_model_byte(100, b, w);
      tests_run++; if (b !== 8'h55) begin tests_failed++; $display("FAIL tx1_byte: got %h required 55", b); end
      tests_run++; if (w !== 2) begin tests_failed++; $display("FAIL tx1_pulse_width: got %0d required 2", w); end
      bus_read(CON, v);
      tests_run++; if (v !== 32'h11) begin tests_failed++; $display("FAIL tx1_con_busy: got %h required 00000011", v); end
      tests_run++; if (writedata !== 8'h55) begin tests_failed++; $display("FAIL tx1_writedata_held: got %h required 55", writedata); end
      repeat (6) @(negedge sysclk);
      bus_read(CON, v);
      tests_run++; if (v !== 32'h01) begin tests_failed++; $display("FAIL tx1_con_idle: got %h required 00000001", v); end
   endtask

   task automatic test_tx_fifo_order();
      logic [31:0] v;
      logic [7:0]  b;
      logic [7:0]  exp_b [4];
      int          w;
      int          extra;
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
      bus_write(CON, 32'h00);
      bus_write(TXD, 32'h11);
      bus_write(TXD, 32'h22);
      bus_write(TXD, 32'h33);
      bus_write(TXD, 32'h44);
      bus_write(TXD, 32'h66);
      bus_read(CON, v);
      tests_run++; if (v !== 32'h84) begin tests_failed++; $display("FAIL txq_con_full_ovf: got %h required 00000084", v); end
      bus_write(CON, 32'h01);
      for (int i = 0; i < 4; i++) begin
         tx_model_byte(10, b, w);
         tests_run++; if (b !== exp_b[i]) begin tests_failed++; $display("FAIL txq_byte%0d: got %h required %h", i, b, exp_b[i]); end
         tests_run++; if (w !== 2) begin tests_failed++; $display("FAIL txq_width%0d: got %0d required 2", i, w); end
      end
      extra = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge sysclk);
         if (send_trigger === 1'b0) extra++;
      end
      tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL txq_no_fifth_byte: got %0d trigger-low cycles required 0", extra); end
      bus_read(CON, v);
      tests_run++; if (v !== 32'h81) begin tests_failed++; $display("FAIL txq_con_after: got %h required 00000081", v); end
      bus_write(CON, 32'h80);
      bus_read(CON, v);
      tests_run++; if (v !== 32'h00) begin tests_failed++; $display("FAIL txq_ovf_clear: got %h required 00000000", v); end
   endtask

   task automatic test_rx_single();
      logic [31:0] v;
      int          w;
      bus_write(CON, 32'h02);
      rx_model_byte(8'hA5, w);
      tests_run++; if (w !== 2) begin tests_failed++; $display("FAIL rx1_ack_width: got %0d required 2", w); end
      bus_read(CON, v);
      tests_run++; if (v !== 32'h0A) begin tests_failed++; $display("FAIL rx1_con: got %h required 0000000a", v); end
      bus_read(RXD, v);
      tests_run++; if (v !== 32'h0000_00A5) begin tests_failed++; $display("FAIL rx1_rxd_first: got %h required 000000a5", v); end
      bus_read(RXD, v);
      tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL rx1_rxd_empty: got %h required 00000000", v); end
   endtask

   task automatic test_rx_overflow();
      logic [31:0] v;
      logic [7:0]  bytes [5];
      int          w;
      bytes = '{8'h01, 8'h5A, 8'hC3, 8'h7E, 8'hFF};
      for (int i = 0; i < 5; i++) begin
         rx_model_byte(bytes[i], w);
         tests_run++; if (w !== 2) begin tests_failed++; $display("FAIL rxo_ack%0d: got width %0d required 2", i, w); end
      end
      bus_read(CON, v);
      tests_run++; if (v !== 32'h2A) begin tests_failed++; $display("FAIL rxo_con_ovf: got %h required 0000002a", v); end
      for (int i = 0; i < 4; i++) begin
         bus_read(RXD, v);
         tests_run++; if (v !== {24'h0, bytes[i]}) begin tests_failed++; $display("FAIL rxo_rxd%0d: got %h required %h", i, v, {24'h0, bytes[i]}); end
      end
      bus_read(CON, v);
      tests_run++; if (v !== 32'h22) begin tests_failed++; $display("FAIL rxo_con_drained: got %h required 00000022", v); end
      bus_write(CON, 32'h22);
      bus_read(CON, v);
      tests_run++; if (v !== 32'h02) begin tests_failed++; $display("FAIL rxo_ovf_clear: got %h required 00000002", v); end
   endtask

   task automatic test_irq();
      bus_write(CON, 32'h40);
      tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_latency: got %b required 0", irq); end
      @(negedge sysclk);
      tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_tx_empty: got %b required 1", irq); end
      bus_write(CON, 32'h00);
      @(negedge sysclk);
      tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_disabled: got %b required 0", irq); end
   endtask

   task automatic test_reset_mid_tx();
      logic [31:0] v;
      logic [7:0]  b;
      int          w;
      logic        seen;
      bus_write(CON, 32'h01);
      bus_write(TXD, 32'h77);
      bus_write(TXD, 32'h78);
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (send_trigger === 1'b0) begin seen = 1'b1; break; end
         @(negedge sysclk);
      end
      tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL rst_trig_seen: got %b required 1", seen); end
      reset = 1'b1;
      #1;
      tests_run++; if (send_trigger !== 1'b1) begin tests_failed++; $display("FAIL rst_trig_high: got %b required 1", send_trigger); end
      tests_run++; if (send_enable !== 1'b0 || writedata !== 8'h00) begin tests_failed++; $display("FAIL rst_outputs: got en=%b wd=%h required en=0 wd=00", send_enable, writedata); end
      repeat (2) @(negedge sysclk);
      reset = 1'b0;
      bus_read(CON, v);
      tests_run++; if (v !== 32'h00) begin tests_failed++; $display("FAIL rst_con: got %h required 00000000", v); end
      bus_write(CON, 32'h40);
      @(negedge sysclk);
      tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL rst_tx_fifo_empty_irq: got %b required 1", irq); end
      bus_write(CON, 32'h01);
      bus_write(TXD, 32'h99);
      tx_model_byte(10, b, w);
      tests_run++; if (b !== 8'h99) begin tests_failed++; $display("FAIL rst_after_byte: got %h required 99", b); end
      tests_run++; if (w !== 2) begin tests_failed++; $display("FAIL rst_after_width: got %0d required 2", w); end
      repeat (6) @(negedge sysclk);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1;
      addr = 32'h0; mem_wr = 1'b0; mem_rd = 1'b0; wdata = 32'h0;
      send_state = 1'b1; recv_state = 1'b0; readdata = 8'h00;
      test_reset();
      test_tx_single();
      test_tx_fifo_order();
      test_rx_single();
      test_rx_overflow();
      test_irq();
      test_reset_mid_tx();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
Memory-mapped bridge between the single-cycle CPU data bus and the UART transceiver wrapper. It buffers CPU-written bytes in a TX FIFO and drives the wrapper's send handshake one byte at a time. Received bytes are captured into an RX FIFO, and the bridge acknowledges the wrapper's receive flag. It also exposes a status/control register and an interrupt line to the CPU.

Parameters:
BASE_ADDR, 32'h4000_0018, byte address of TXD; RXD = BASE+4, CON = BASE+8
FIFO_DEPTH, 4, entries per FIFO (power of two, >=2)
PULSE_CYCLES, 2, low-pulse width of send_trigger and Uart_state_trigger in sysclk cycles

Ports:
sysclk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
addr  in  32  CPU byte address
mem_wr  in  1  CPU write strobe
mem_rd  in  1  CPU read strobe
wdata  in  32  CPU write data
rdata  out  32  CPU read data (combinational from addr; 0 when unmapped)
irq  out  1  level interrupt
writedata  out  8  byte to transceiver
send_trigger  out  1  active-low send request pulse, idles high
send_enable  out  1  CON[0]
send_state  in  1  high = transmitter idle/done, low = byte in flight
recv_enable  out  1  CON[1]
recv_state  in  1  high = byte available on readdata
Uart_state_trigger  out  1  active-low receive acknowledge pulse, idles high
readdata  in  8  received byte

Behaviour:
- Reset values: rdata=0, irq=0, writedata=0, send_trigger=1, Uart_state_trigger=1, send_enable=0, recv_enable=0, both FIFOs empty, sticky flags 0, both FSMs IDLE.
- send_state and recv_state are asynchronous to sysclk. Each passes through a 2-FF synchronizer before use.
- Bus writes:
  - TXD (mem_wr & addr==BASE): push wdata[7:0] into the TX FIFO. If the FIFO is full, drop the byte and set tx_ovf.
  - CON write: bit0→send_enable, bit1→recv_enable, bit6→irq_en. Bits 5 and 7 are write-1-to-clear for rx_ovf and tx_ovf.
- Bus reads:
  - RXD read returns {24'b0, RX FIFO head}, or 0 if the FIFO is empty. The pop happens at the clock edge where mem_rd & addr==RXD & !empty.
  - CON read = {24'b0, tx_ovf, irq_en, rx_ovf, tx_busy, rx_nonempty, tx_full, recv_enable, send_enable}.
- TX FSM:
  - IDLE→LOAD when the FIFO is non-empty and send_enable=1. In LOAD, pop the head into writedata.
  - LOAD→TRIG next cycle. send_trigger is driven 0 for PULSE_CYCLES, then returns to 1.
  - TRIG→WAIT_BUSY. Wait for the synchronized send_state to be 0.
  - WAIT_BUSY→WAIT_DONE. Wait for the synchronized send_state to be 1.
  - WAIT_DONE→IDLE.
  - tx_busy = state!=IDLE. writedata is held stable from LOAD through WAIT_DONE.
  - Clearing send_enable mid-byte does not abort the byte; it only blocks the next LOAD.
- RX FSM:
  - IDLE→CAPTURE on a synchronized recv_state rising edge while recv_enable=1.
  - CAPTURE: push readdata. If the FIFO is full, drop the byte and set rx_ovf; the ack is still sent.
  - CAPTURE→ACK. Uart_state_trigger is driven 0 for PULSE_CYCLES.
  - ACK→WAIT_CLR. Wait for the synchronized recv_state to be 0, then return to IDLE.
- Simultaneous push and pop on one FIFO in the same cycle: both occur and the count is unchanged. A push to a full FIFO is never accepted, even with a pop in the same cycle.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide: equal pointers = empty; MSB differs and the rest are equal = full. Pointers wrap naturally.
- irq = irq_en & (rx_nonempty | (!tx_busy & tx_empty)). irq is a registered output, 1-cycle latency.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight trigger pulse ends with the output high; FIFO contents are discarded.

Decomposition:
- Shared package: address offsets (TXD/RXD/CON), CON bit indices, TX and RX FSM state encodings.
- One sub-module: uart_byte_fifo (parameter DEPTH; ports push/pop/din/dout/full/empty), instantiated twice.

Test Plan:
- Reset then read CON → 0x00; send_trigger=1, Uart_state_trigger=1, irq=0.
- CON←0x01, TXD←0x55: writedata=0x55, send_trigger low for exactly 2 cycles. Model drops send_state for 100 cycles, then raises it → FSM back to IDLE, CON[4]=0.
- Write 0x11,0x22,0x33,0x44,0x66 with send_enable=0 → CON[2]=1, CON[7]=1. Enable → bytes sent in order 11,22,33,44 only. CON←0x80 clears CON[7].
- CON←0x02, model presents readdata=0xA5 and raises recv_state → Uart_state_trigger pulses low 2 cycles, CON[3]=1. RXD read returns 0x000000A5, next read returns 0.
- Five received bytes with no CPU reads → first four retained in order, CON[5]=1, every byte still acknowledged.
- Assert reset during TRIG → send_trigger returns to 1, FIFOs empty, enables 0; after release the bridge accepts a new TXD write normally.
